// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for a MIPS subset, with request/ready handshakes to both memories.
// Optional performance counters are built when MULTICYCLE_CTRL_PERF_EN is defined.
module multicycle_control #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] instr,
  input  logic             equal,
  input  logic             im_ready,
  input  logic             dm_ready,
  output logic             im_req,
  output logic             dm_req,
  output logic             dm_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       rf_wa_sel,
  output logic [1:0]       rf_wd_sel,
  output logic [1:0]       alu_op,
  output logic [1:0]       alu_srcb,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cyc_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    K_NOP, K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR
  } kind_t;

  state_t state_q, state_d;
  kind_t  kind;
  logic   instr_unused;

  // Only opcode and funct steer control; the rest of the word belongs to the datapath.
  assign instr_unused = ^instr;

  always_comb begin
    kind = K_NOP;
    case (instr[31:26])
      6'h00: begin
        case (instr[5:0])
          6'h21:   kind = K_ADDU;
          6'h23:   kind = K_SUBU;
          6'h08:   kind = K_JR;
          default: kind = K_NOP;
        endcase
      end
      6'h02:   kind = K_J;
      6'h03:   kind = K_JAL;
      6'h04:   kind = K_BEQ;
      6'h0D:   kind = K_ORI;
      6'h0F:   kind = K_LUI;
      6'h23:   kind = K_LW;
      6'h2B:   kind = K_SW;
      default: kind = K_NOP;
    endcase
  end

  // Handshake: im_req/dm_req rise when their state is entered and stay high until the
  // matching ready is seen in that state; ready outside its own state is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (im_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (kind)
          K_J, K_JAL, K_JR, K_NOP: state_d = S_FETCH;
          default:                 state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (kind)
          K_LW, K_SW: state_d = S_MEM;
          K_BEQ:      state_d = S_FETCH;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM:   if (dm_ready) state_d = (kind == K_LW) ? S_WB : S_FETCH;
      S_WB:    state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    im_req    = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    rf_we     = 1'b0;
    rf_wa_sel = 2'd0;
    rf_wd_sel = 2'd0;
    alu_op    = 2'd0;
    alu_srcb  = 2'd0;
    case (state_q)
      S_FETCH: begin
        im_req = 1'b1;
        ir_we  = im_ready;
        pc_we  = im_ready;
      end
      S_DECODE: begin
        case (kind)
          K_J:   begin pc_we = 1'b1; pc_sel = 2'd2; end
          K_JR:  begin pc_we = 1'b1; pc_sel = 2'd3; end
          K_JAL: begin
            pc_we = 1'b1; pc_sel = 2'd2;
            rf_we = 1'b1; rf_wa_sel = 2'd2; rf_wd_sel = 2'd2;
          end
          default: ;
        endcase
      end
      S_EXEC: begin
        case (kind)
          K_SUBU:     alu_op = 2'd1;
          K_ORI:      begin alu_op = 2'd2; alu_srcb = 2'd1; end
          K_LUI:      begin alu_op = 2'd3; alu_srcb = 2'd1; end
          K_LW, K_SW: alu_srcb = 2'd2;
          K_BEQ:      begin pc_we = equal; pc_sel = 2'd1; end
          default: ;
        endcase
      end
      S_MEM: begin
        // Address computation stays selected so the ALU output is stable for the access.
        dm_req   = 1'b1;
        dm_we    = (kind == K_SW);
        alu_srcb = 2'd2;
      end
      S_WB: begin
        rf_we = 1'b1;
        case (kind)
          K_ADDU, K_SUBU: rf_wa_sel = 2'd1;
          K_LW:           rf_wd_sel = 2'd1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign state = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_W-1:0] instr_cnt_q, cyc_cnt_q;
  logic             retire;

  assign retire = (state_d == S_FETCH) && (state_q != S_IDLE) && (state_q != S_FETCH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_cnt_q <= '0;
      cyc_cnt_q   <= '0;
    end else begin
      if (state_q != S_IDLE) cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
      if (retire)            instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  assign instr_cnt = instr_cnt_q;
  assign cyc_cnt   = cyc_cnt_q;
`else
  assign instr_cnt = '0;
  assign cyc_cnt   = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected control vectors in a queue.
// Counter expectations follow MULTICYCLE_CTRL_PERF_EN.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr;
  logic        equal, im_ready, dm_ready;
  logic        im_req, dm_req, dm_we, ir_we, pc_we, rf_we;
  logic [1:0]  pc_sel, rf_wa_sel, rf_wd_sel, alu_op, alu_srcb;
  logic [2:0]  state;
  logic [31:0] instr_cnt, cyc_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [34:0] stim_q[$];
  logic [18:0] exp_q[$];

`ifdef MULTICYCLE_CTRL_PERF_EN
  localparam logic [31:0] EXP_IC = 32'd3;
  localparam logic [31:0] EXP_CC = 32'd11;
`else
  localparam logic [31:0] EXP_IC = 32'd0;
  localparam logic [31:0] EXP_CC = 32'd0;
`endif

  localparam logic [18:0] F_WAIT = {3'd1, 1'b1, 15'd0};
  localparam logic [18:0] F_DONE = {3'd1, 1'b1, 2'b00, 2'b11, 11'd0};
  localparam logic [18:0] DEC0   = {3'd2, 16'd0};

  localparam logic [31:0] ADDU = 32'h0085_1021, SUBU = 32'h0085_1023;
  localparam logic [31:0] ORI  = 32'h34A5_001F, LUI  = 32'h3C05_1234;
  localparam logic [31:0] LW   = 32'h8C85_0004, SW   = 32'hAC85_0004;
  localparam logic [31:0] BEQ  = 32'h1085_0003, J    = 32'h0800_0010;
  localparam logic [31:0] JAL  = 32'h0C00_0C10, JR   = 32'h03E0_0008;
  localparam logic [31:0] NOP  = 32'h0000_0000, BADOP = 32'hFC00_0000;
  localparam logic [31:0] BADFN = 32'h0085_1020;

  multicycle_control #(.WIDTH(32), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .equal(equal),
    .im_ready(im_ready), .dm_ready(dm_ready),
    .im_req(im_req), .dm_req(dm_req), .dm_we(dm_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .rf_wa_sel(rf_wa_sel),
    .rf_wd_sel(rf_wd_sel), .alu_op(alu_op), .alu_srcb(alu_srcb),
    .state(state), .instr_cnt(instr_cnt), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  // Expected vector layout: {state, im_req, dm_req, dm_we, ir_we, pc_we, pc_sel, rf_we, wa, wd, alu_op, srcb}
  function automatic logic [18:0] cv(input logic [2:0] st, input logic im, dmr, dmw, irw, pcw,
                                     input logic [1:0] psel, input logic rfw,
                                     input logic [1:0] wa, wd, op, sb);
    return {st, im, dmr, dmw, irw, pcw, psel, rfw, wa, wd, op, sb};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {state, im_req, dm_req, dm_we, ir_we, pc_we, pc_sel, rf_we,
            rf_wa_sel, rf_wd_sel, alu_op, alu_srcb};
  endfunction

  function automatic logic r1();
    return 1'($urandom_range(0, 1));
  endfunction

  // Driver: queue one cycle of stimulus together with the control vector it must produce.
  task automatic push(input logic [31:0] ins, input logic ir, dr, eq, input logic [18:0] e);
    stim_q.push_back({ins, ir, dr, eq});
    exp_q.push_back(e);
  endtask

  // Driver: apply the next stimulus after the falling edge and sample mid-cycle.
  task automatic step(output logic [18:0] g, output logic [18:0] e);
    logic [34:0] s;
    @(negedge clk);
    s = stim_q.pop_front();
    instr = s[34:3]; im_ready = s[2]; dm_ready = s[1]; equal = s[0];
    #2;
    g = dut_vec();
    e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; instr = '0; equal = 1'b0; im_ready = 1'b0; dm_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++;
    if (dut_vec() !== 19'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %h expected %h", dut_vec(), 19'd0);
    end
    n_assert++;
    if ({instr_cnt, cyc_cnt} !== 64'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %h/%h expected 0/0", instr_cnt, cyc_cnt);
    end
    reset_n = 1'b1;
    #2;
    n_assert++;
    if (dut_vec() !== 19'd0) begin
      n_fail++; $display("FAIL release_idle: got %h expected %h", dut_vec(), 19'd0);
    end
  endtask

  task automatic test_fetch_wait_addu();
    logic [18:0] g, e;
    int i = 0;
    repeat (3) push(ADDU, 1'b0, r1(), r1(), F_WAIT);
    push(ADDU, 1'b1, r1(), r1(), F_DONE);
    push(ADDU, r1(), r1(), r1(), DEC0);
    push(ADDU, r1(), r1(), r1(), cv(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(ADDU, r1(), r1(), r1(), cv(5, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      step(g, e); n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL addu_wait[%0d]: got %h expected %h", i, g, e); end
      i++;
    end
  endtask

  task automatic test_beq();
    logic [18:0] g, e;
    int i = 0;
    push(BEQ, 1'b1, r1(), r1(), F_DONE);
    push(BEQ, r1(), r1(), r1(), DEC0);
    push(BEQ, r1(), r1(), 1'b1, cv(3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    push(BEQ, 1'b1, r1(), r1(), F_DONE);
    push(BEQ, r1(), r1(), r1(), DEC0);
    push(BEQ, r1(), r1(), 1'b0, cv(3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      step(g, e); n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL beq[%0d]: got %h expected %h", i, g, e); end
      i++;
    end
  endtask

  task automatic test_jumps();
    logic [18:0] g, e;
    int i = 0;
    push(JAL, 1'b1, r1(), r1(), F_DONE);
    push(JAL, r1(), r1(), r1(), cv(2, 0, 0, 0, 0, 1, 2, 1, 2, 2, 0, 0));
    push(J, 1'b1, r1(), r1(), F_DONE);
    push(J, r1(), r1(), r1(), cv(2, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
    push(JR, 1'b1, r1(), r1(), F_DONE);
    push(JR, r1(), r1(), r1(), cv(2, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0));
    push(JR, 1'b0, r1(), r1(), F_WAIT);
    while (exp_q.size() > 0) begin
      step(g, e); n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL jumps[%0d]: got %h expected %h", i, g, e); end
      i++;
    end
  endtask

  task automatic test_nop_unknown();
    logic [18:0] g, e;
    int i = 0;
    push(NOP, 1'b1, r1(), r1(), F_DONE);
    push(NOP, r1(), r1(), r1(), DEC0);
    push(BADOP, 1'b1, r1(), r1(), F_DONE);
    push(BADOP, r1(), r1(), r1(), DEC0);
    push(BADFN, 1'b1, r1(), r1(), F_DONE);
    push(BADFN, r1(), r1(), r1(), DEC0);
    push(BADFN, 1'b0, r1(), r1(), F_WAIT);
    while (exp_q.size() > 0) begin
      step(g, e); n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL nop_unknown[%0d]: got %h expected %h", i, g, e); end
      i++;
    end
  endtask

  task automatic test_alu_ops();
    logic [18:0] g, e;
    int i = 0;
    push(ORI, 1'b1, r1(), r1(), F_DONE);
    push(ORI, r1(), r1(), r1(), DEC0);
    push(ORI, r1(), r1(), r1(), cv(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1));
    push(ORI, r1(), r1(), r1(), cv(5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    push(LUI, 1'b1, r1(), r1(), F_DONE);
    push(LUI, r1(), r1(), r1(), DEC0);
    push(LUI, r1(), r1(), r1(), cv(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1));
    push(LUI, r1(), r1(), r1(), cv(5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    push(SUBU, 1'b1, r1(), r1(), F_DONE);
    push(SUBU, r1(), r1(), r1(), DEC0);
    push(SUBU, r1(), r1(), r1(), cv(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    push(SUBU, r1(), r1(), r1(), cv(5, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      step(g, e); n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL alu_ops[%0d]: got %h expected %h", i, g, e); end
      i++;
    end
  endtask

  task automatic test_sw_wait();
    logic [18:0] g, e;
    int i = 0;
    push(SW, 1'b1, r1(), r1(), F_DONE);
    push(SW, r1(), r1(), r1(), DEC0);
    push(SW, r1(), r1(), r1(), cv(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    push(SW, r1(), 1'b0, r1(), cv(4, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2));
    push(SW, r1(), 1'b1, r1(), cv(4, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2));
    push(SW, 1'b0, r1(), r1(), F_WAIT);
    while (exp_q.size() > 0) begin
      step(g, e); n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL sw_wait[%0d]: got %h expected %h", i, g, e); end
      i++;
    end
  endtask

  task automatic test_lw();
    logic [18:0] g, e;
    int i = 0;
    push(LW, 1'b1, r1(), r1(), F_DONE);
    push(LW, r1(), r1(), r1(), DEC0);
    push(LW, r1(), r1(), r1(), cv(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    push(LW, r1(), 1'b1, r1(), cv(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    push(LW, r1(), r1(), r1(), cv(5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    while (exp_q.size() > 0) begin
      step(g, e); n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL lw[%0d]: got %h expected %h", i, g, e); end
      i++;
    end
  endtask

  task automatic test_reset_mid_lw();
    logic [18:0] g, e;
    int i = 0;
    push(LW, 1'b1, r1(), r1(), F_DONE);
    push(LW, r1(), r1(), r1(), DEC0);
    push(LW, r1(), r1(), r1(), cv(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    repeat (2) push(LW, r1(), 1'b0, r1(), cv(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    while (exp_q.size() > 0) begin
      step(g, e); n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL mid_lw[%0d]: got %h expected %h", i, g, e); end
      i++;
    end
    @(posedge clk); #3;
    n_assert++;
    if ({state, dm_req} !== {3'd4, 1'b1}) begin
      n_fail++; $display("FAIL mid_lw_hold: got state %0d dm_req %b expected 4/1", state, dm_req);
    end
    reset_n = 1'b0;
    #1;
    n_assert++;
    if (dut_vec() !== 19'd0) begin
      n_fail++; $display("FAIL async_reset: got %h expected %h", dut_vec(), 19'd0);
    end
    n_assert++;
    if ({instr_cnt, cyc_cnt} !== 64'd0) begin
      n_fail++; $display("FAIL async_reset_cnt: got %h/%h expected 0/0", instr_cnt, cyc_cnt);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    n_assert++;
    if (dut_vec() !== 19'd0) begin
      n_fail++; $display("FAIL rerelease_idle: got %h expected %h", dut_vec(), 19'd0);
    end
    @(posedge clk); #2;
    n_assert++;
    if (state !== 3'd1) begin
      n_fail++; $display("FAIL rerelease_fetch: got state %0d expected 1", state);
    end
  endtask

  task automatic test_perf_counters();
    logic [18:0] g, e;
    int i = 0;
    push(NOP, 1'b1, r1(), r1(), F_DONE);
    push(NOP, r1(), r1(), r1(), DEC0);
    push(ORI, 1'b1, r1(), r1(), F_DONE);
    push(ORI, r1(), r1(), r1(), DEC0);
    push(ORI, r1(), r1(), r1(), cv(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1));
    push(ORI, r1(), r1(), r1(), cv(5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    push(LW, 1'b1, r1(), r1(), F_DONE);
    push(LW, r1(), r1(), r1(), DEC0);
    push(LW, r1(), r1(), r1(), cv(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    push(LW, r1(), 1'b1, r1(), cv(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    push(LW, r1(), r1(), r1(), cv(5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    push(NOP, 1'b0, r1(), r1(), F_WAIT);
    while (exp_q.size() > 0) begin
      step(g, e); n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL perf_prog[%0d]: got %h expected %h", i, g, e); end
      i++;
    end
    n_assert++;
    if (instr_cnt !== EXP_IC) begin
      n_fail++; $display("FAIL instr_cnt: got %0d expected %0d", instr_cnt, EXP_IC);
    end
    n_assert++;
    if (cyc_cnt !== EXP_CC) begin
      n_fail++; $display("FAIL cyc_cnt: got %0d expected %0d", cyc_cnt, EXP_CC);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_wait_addu();
    test_beq();
    test_jumps();
    test_nop_unknown();
    test_alu_ops();
    test_sw_wait();
    test_lw();
    test_reset_mid_lw();
    test_perf_counters();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
